// File: rtl/multicycle_controller.sv
// multicycle_controller: multi-cycle FSM sequencing a shared-memory datapath with run/halt,
// a wait-state watchdog and a retired-instruction counter.
module multicycle_controller #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic [6:0]       funct7,
  input  logic [2:0]       funct3,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             i_or_d,
  output logic             pc_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             mem2reg,
  output logic             alu_src,
  output logic             mem_read,
  output logic             mem_write,
  output logic [3:0]       alu_cc,
  output logic             illegal,
  output logic             error,
  output logic [CNT_W-1:0] instr_count
);
  localparam int WW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LW = 7'b0000011, OP_SW = 7'b0100011;
  localparam logic [3:0] CC_ADD = 4'b0010;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC, S_WB_ALU, S_ADDR, S_MEM_RD, S_WB_MEM, S_MEM_WR, S_ERROR
  } state_t;

  state_t           r_state, w_next;
  logic [WW-1:0]    r_wait;
  logic [CNT_W-1:0] r_count;
  logic             w_r, w_i, w_lw, w_sw, w_last, w_retire;
  logic [3:0]       w_cc;

  assign w_r    = opcode == OP_R;
  assign w_i    = opcode == OP_I;
  assign w_lw   = opcode == OP_LW;
  assign w_sw   = opcode == OP_SW;
  assign w_last = r_wait == WW'(MAX_WAIT - 1);
  assign w_cc   = funct3 == 3'b000 ? ((w_r && funct7 == 7'b0100000) ? 4'b0110 : CC_ADD) :
                  funct3 == 3'b111 ? 4'b0000 :
                  funct3 == 3'b110 ? 4'b0001 :
                  funct3 == 3'b100 ? 4'b1100 :
                  funct3 == 3'b010 ? 4'b0111 : CC_ADD;
  assign instr_count = r_count;

  always_comb begin
    w_next    = r_state;
    w_retire  = 1'b0;
    mem_req   = 1'b0;
    i_or_d    = 1'b0;
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    mem2reg   = 1'b0;
    alu_src   = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    alu_cc    = 4'b0000;
    illegal   = 1'b0;
    error     = 1'b0;
    case (r_state)
      // a fetch already waiting keeps its request up even if run drops
      S_FETCH: begin
        mem_req  = run || r_wait != '0;
        mem_read = mem_req;
        pc_write = mem_req && mem_ready;
        ir_write = pc_write;
        w_next   = pc_write ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        illegal = !(w_r || w_i || w_lw || w_sw);
        w_next  = (w_r || w_i) ? S_EXEC : (w_lw || w_sw) ? S_ADDR : S_FETCH;
      end
      S_EXEC: begin
        alu_src = w_i;
        alu_cc  = w_cc;
        w_next  = S_WB_ALU;
      end
      S_WB_ALU: begin
        alu_src   = w_i;
        alu_cc    = w_cc;
        reg_write = 1'b1;
        w_retire  = 1'b1;
        w_next    = S_FETCH;
      end
      S_ADDR: begin
        alu_src = 1'b1;
        alu_cc  = CC_ADD;
        w_next  = w_lw ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        alu_src  = 1'b1;
        alu_cc   = CC_ADD;
        mem_req  = 1'b1;
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        w_next   = mem_ready ? S_WB_MEM : S_MEM_RD;
      end
      S_WB_MEM: begin
        alu_src   = 1'b1;
        alu_cc    = CC_ADD;
        reg_write = 1'b1;
        mem2reg   = 1'b1;
        w_retire  = 1'b1;
        w_next    = S_FETCH;
      end
      S_MEM_WR: begin
        alu_src   = 1'b1;
        alu_cc    = CC_ADD;
        mem_req   = 1'b1;
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        w_retire  = mem_ready;
        w_next    = mem_ready ? S_FETCH : S_MEM_WR;
      end
      S_ERROR: error = 1'b1;
      default: w_next = S_FETCH;
    endcase
    if (mem_req && !mem_ready && w_last) begin
      w_next   = S_ERROR;
      w_retire = 1'b0;
    end
    // outputs are forced low for as long as reset is held, without waiting for a clock
    if (!reset) begin
      {mem_req, i_or_d, pc_write, ir_write, reg_write, mem2reg, alu_src, mem_read, mem_write} = '0;
      alu_cc  = 4'b0000;
      illegal = 1'b0;
      error   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
      r_wait  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      r_wait  <= (mem_req && !mem_ready && !w_last) ? r_wait + 1'b1 : '0;
      if (w_retire) r_count <= r_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed and random instruction sequences checked cycle by cycle
// against per-instruction output traces built from the latency and strobe rules.
module tb_multicycle_controller;
  localparam int MW = 4;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LW = 7'b0000011, OP_SW = 7'b0100011;

  logic        clk = 1'b0, reset = 1'b0, run = 1'b0, mem_ready = 1'b0;
  logic [6:0]  opcode = '0, funct7 = '0;
  logic [2:0]  funct3 = '0;
  logic        mem_req, i_or_d, pc_write, ir_write, reg_write, mem2reg, alu_src, mem_read, mem_write;
  logic        illegal, error;
  logic [3:0]  alu_cc;
  logic [31:0] instr_count;
  logic [14:0] obs;

  typedef struct packed {logic rdy; logic run; logic [14:0] exp;} step_t;
  step_t       q[$];
  int          n_cmp = 0, n_err = 0;
  logic [31:0] m_cnt = '0;

  multicycle_controller #(.MAX_WAIT(MW), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .funct7(funct7), .funct3(funct3),
    .mem_ready(mem_ready), .mem_req(mem_req), .i_or_d(i_or_d), .pc_write(pc_write),
    .ir_write(ir_write), .reg_write(reg_write), .mem2reg(mem2reg), .alu_src(alu_src),
    .mem_read(mem_read), .mem_write(mem_write), .alu_cc(alu_cc), .illegal(illegal),
    .error(error), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  assign obs = {mem_req, i_or_d, pc_write, ir_write, reg_write, mem2reg, alu_src, mem_read,
                mem_write, alu_cc, illegal, error};

  function automatic logic [14:0] v(input logic req, iod, pcw, irw, rw, m2r, as, mrd, mwr,
                                    input logic [3:0] cc, input logic ill, err);
    return {req, iod, pcw, irw, rw, m2r, as, mrd, mwr, cc, ill, err};
  endfunction

  function automatic logic [3:0] ref_cc(input logic isr, input logic [6:0] f7, input logic [2:0] f3);
    case (f3)
      3'b000:  return (isr && f7 == 7'b0100000) ? 4'b0110 : 4'b0010;
      3'b111:  return 4'b0000;
      3'b110:  return 4'b0001;
      3'b100:  return 4'b1100;
      3'b010:  return 4'b0111;
      default: return 4'b0010;
    endcase
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(1));
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic push(input logic rdy, input logic r, input logic [14:0] e);
    q.push_back({rdy, r, e});
  endtask

  task automatic play(input string tag);
    foreach (q[i]) begin
      @(negedge clk);
      mem_ready = q[i].rdy;
      run = q[i].run;
      #1;
      chk($sformatf("%s[%0d]", tag, i), 32'(obs), 32'(q[i].exp));
    end
    q.delete();
  endtask

  task automatic build(input int wf, input int wm, input logic ra);
    logic isr, isi, islw, issw;
    logic [3:0] cc;
    logic [14:0] mv;
    isr = opcode == OP_R; isi = opcode == OP_I; islw = opcode == OP_LW; issw = opcode == OP_SW;
    cc = ref_cc(isr, funct7, funct3);
    repeat (wf) push(1'b0, 1'b1, v(1,0,0,0,0,0,0,1,0,4'b0,0,0));
    push(1'b1, 1'b1, v(1,0,1,1,0,0,0,1,0,4'b0,0,0));
    if (isr || isi) begin
      push(rnd(), ra, '0);
      push(rnd(), ra, v(0,0,0,0,0,0,isi,0,0,cc,0,0));
      push(rnd(), ra, v(0,0,0,0,1,0,isi,0,0,cc,0,0));
    end else if (islw || issw) begin
      mv = islw ? v(1,1,0,0,0,0,1,1,0,4'b0010,0,0) : v(1,1,0,0,0,0,1,0,1,4'b0010,0,0);
      push(rnd(), ra, '0);
      push(rnd(), ra, v(0,0,0,0,0,0,1,0,0,4'b0010,0,0));
      repeat (wm) push(1'b0, ra, mv);
      push(1'b1, ra, mv);
      if (islw) push(rnd(), ra, v(0,0,0,0,1,1,1,0,0,4'b0010,0,0));
    end else
      push(rnd(), ra, v(0,0,0,0,0,0,0,0,0,4'b0,1,0));
  endtask

  task automatic run_instr(input string tag, input logic [6:0] op, input logic [6:0] f7,
                           input logic [2:0] f3, input int wf, input int wm, input logic ra);
    opcode = op; funct7 = f7; funct3 = f3;
    build(wf, wm, ra);
    play(tag);
    @(posedge clk);
    #1;
    if (op == OP_R || op == OP_I || op == OP_LW || op == OP_SW) m_cnt++;
    chk({tag, ".cnt"}, instr_count, m_cnt);
  endtask

  initial begin
    logic [6:0] op;
    reset = 1'b0; run = 1'b1; mem_ready = 1'b1;
    #2;
    chk("rst.out", 32'(obs), 32'h0);
    chk("rst.cnt", instr_count, 32'h0);
    @(posedge clk); #1;
    chk("rst.hold", 32'(obs), 32'h0);
    @(negedge clk);
    run = 1'b0; reset = 1'b1;
    #1;
    chk("idle.run0", 32'(obs), 32'h0);

    run_instr("addi", OP_I, 7'b0, 3'b000, 0, 0, 1'b1);
    run_instr("sub", OP_R, 7'b0100000, 3'b000, 0, 0, 1'b1);
    run_instr("nor", OP_R, 7'b0100000, 3'b100, 0, 0, 1'b1);
    run_instr("lw_wait3", OP_LW, 7'b0, 3'b010, 0, 3, 1'b1);
    run_instr("sw_fw2", OP_SW, 7'b0, 3'b010, 2, 1, 1'b1);
    run_instr("drop", OP_R, 7'b0, 3'b111, 1, 0, 1'b0);
    repeat (3) push(rnd(), 1'b0, '0);
    play("drop.idle");

    for (int k = 0; k < 30; k++) begin
      case ($urandom_range(4))
        0: op = OP_R;
        1: op = OP_I;
        2: op = OP_LW;
        3: op = OP_SW;
        default: begin
          op = 7'($urandom);
          if (op == OP_R || op == OP_I || op == OP_LW || op == OP_SW) op ^= 7'b1000000;
        end
      endcase
      run_instr($sformatf("rnd%0d", k), op, 7'($urandom), 3'($urandom),
                $urandom_range(MW - 1), $urandom_range(MW - 1), 1'b1);
    end

    opcode = OP_LW; funct3 = 3'b010;
    push(1'b1, 1'b1, v(1,0,1,1,0,0,0,1,0,4'b0,0,0));
    push(1'b0, 1'b1, '0);
    push(1'b0, 1'b1, v(0,0,0,0,0,0,1,0,0,4'b0010,0,0));
    push(1'b0, 1'b1, v(1,1,0,0,0,0,1,1,0,4'b0010,0,0));
    play("lw_rst");
    #2 reset = 1'b0;
    #1;
    m_cnt = '0;
    chk("rst_async.out", 32'(obs), 32'h0);
    chk("rst_async.cnt", instr_count, m_cnt);
    @(posedge clk); #1;
    chk("rst_async.hold", 32'(obs), 32'h0);
    @(negedge clk);
    reset = 1'b1; mem_ready = 1'b0;
    #1;
    chk("rst_rel.fetch", 32'(obs), 32'(v(1,0,0,0,0,0,0,1,0,4'b0,0,0)));
    chk("rst_rel.cnt", instr_count, 32'h0);

    run_instr("and", OP_R, 7'b0, 3'b111, 0, 0, 1'b1);
    run_instr("illegal", 7'b1111111, 7'b0, 3'b000, 0, 0, 1'b0);
    repeat (4) push(rnd(), 1'b0, '0);
    play("halt");

    opcode = OP_SW; funct3 = 3'b010;
    push(1'b1, 1'b1, v(1,0,1,1,0,0,0,1,0,4'b0,0,0));
    push(rnd(), 1'b1, '0);
    push(rnd(), 1'b1, v(0,0,0,0,0,0,1,0,0,4'b0010,0,0));
    repeat (MW) push(1'b0, 1'b1, v(1,1,0,0,0,0,1,0,1,4'b0010,0,0));
    repeat (4) push(rnd(), rnd(), v(0,0,0,0,0,0,0,0,0,4'b0,0,1));
    play("sw_wdog");
    chk("sw_wdog.cnt", instr_count, m_cnt);
    @(negedge clk);
    reset = 1'b0; run = 1'b0;
    #1;
    chk("err_rst.out", 32'(obs), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("err_clear", 32'(obs), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
